// File: rtl/rv_fetch_queue_pkg.sv
// Shared fetch definitions: default XLEN, instruction byte stride and the
// {pc, inst} fetch entry carried through the instruction queue.
package rv_fetch_queue_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned INST_BYTES   = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/rv_inst_fifo.sv
// Registered circular-buffer instruction queue with flush, parametrised by
// depth (power of two) and entry type.
module rv_inst_fifo
  import rv_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  entry_t                       push_data_i,
  input  logic                         pop_i,
  output entry_t                       head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: contents are only observed while non-empty.
  always_ff @(posedge CLK) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge CLK) begin
    if (!RST && !flush_i) assert (!(push_i && full_o));
  end

endmodule

// File: rtl/rv_fetch_queue.sv
// Instruction fetch front end: PC generation, request credit, redirect drop
// accounting and the decoupling queue. Define RV_FETCH_PERF_EN for perf counters.
module rv_fetch_queue
  import rv_fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN            = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef RV_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [31:0]     inflight;
  logic            credit_ok, req_valid, req_fire, rsp_push, inst_pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  fq_entry_t       push_entry, head_entry;

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = !RST && !fifo_empty;
  assign inst_data      = head_entry.inst;
  assign inst_pc        = head_entry.pc;
  assign push_entry     = '{pc: rsp_pc_q, inst: imem_rsp_data};

  // Requests are credited against both memory slots and free queue space, so
  // every response that returns is guaranteed a queue entry.
  always_comb begin
    inflight      = 32'(outstanding_q) + 32'(fifo_count);
    credit_ok     = (32'(outstanding_q) < MAX_OUTSTANDING) && (inflight < DEPTH) && !fifo_full;
    req_valid     = credit_ok && !redirect_valid && !RST;
    req_fire      = req_valid && imem_req_ready;
    rsp_push      = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
    inst_pop      = inst_valid && inst_ready && !redirect_valid;

    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_rsp_valid);

    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
    if (rsp_push) rsp_pc_d = rsp_pc_q + XLEN'(INST_BYTES);
    if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OW'(1);

    // Everything still in flight at a redirect is stale, except a response
    // landing this very cycle, which is discarded directly.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_cnt_d = outstanding_q - OW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  rv_inst_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fq_entry_t)
  ) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .flush_i     (redirect_valid),
    .push_i      (rsp_push),
    .push_data_i (push_entry),
    .pop_i       (inst_pop),
    .head_o      (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

`ifdef RV_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_dropped_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (rsp_push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (imem_rsp_valid && !rsp_push) perf_dropped_q <= perf_dropped_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Self-checking bench for rv_fetch_queue: in-order memory model, queue-level
// reference model checked every cycle, plus directed scenario expectations.
module tb_rv_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
`ifdef RV_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit memHold = 1'b0;

  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
  pend_t memPend[$];
  ent_t  mQ[$];
  logic [31:0] mFetchPc, mRspPc;
  int mOut, mDrop;
  logic [31:0] mFetched, mDropped;

  always #5 CLK = ~CLK;

  rv_fetch_queue #(
    .XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef RV_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0] ^ 16'h1357};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, memory answers in order
  // once a request is at least one cycle old; return mid-cycle for sampling.
  task automatic applyStimulus(input logic rs, input logic rdv, input logic [31:0] rpc,
                               input logic rqr, input logic ir);
    @(posedge CLK);
    #1;
    RST            = rs;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    imem_req_ready = rqr;
    inst_ready     = ir;
    if (!rs && !memHold && memPend.size() > 0 && memPend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instOf(memPend[0].addr);
      void'(memPend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #2;
  endtask

  // Reference model at queue level, compared on every falling edge.
  always @(negedge CLK) begin
    logic expReq, hs, rsp;
    if (RST) begin
      mFetchPc = RESET_PC;
      mRspPc   = RESET_PC;
      mOut     = 0;
      mDrop    = 0;
      mFetched = 0;
      mDropped = 0;
      mQ.delete();
      memPend.delete();
      checkOutput("m_rst_req_valid", imem_req_valid, 1'b0);
      checkOutput("m_rst_inst_valid", inst_valid, 1'b0);
    end else begin
      expReq = (mOut < MAXO) && (mOut + mQ.size() < DEPTH) && !redirect_valid;
      checkOutput("m_req_valid", imem_req_valid, expReq);
      if (expReq) checkOutput("m_req_addr", imem_req_addr, mFetchPc);
      checkOutput("m_inst_valid", inst_valid, mQ.size() != 0);
      if (mQ.size() != 0) begin
        checkOutput("m_inst_pc", inst_pc, mQ[0].pc);
        checkOutput("m_inst_data", inst_data, mQ[0].data);
      end
      if (inst_valid && inst_ready && !redirect_valid)
        checkOutput("e2e_data", inst_data, instOf(inst_pc));
`ifdef RV_FETCH_PERF_EN
      checkOutput("m_perf_fetched", perf_fetched, mFetched);
      checkOutput("m_perf_dropped", perf_dropped, mDropped);
`endif
      if (imem_req_valid && imem_req_ready) memPend.push_back('{imem_req_addr, cyc + 1});
      hs  = expReq && imem_req_ready;
      rsp = imem_rsp_valid;
      if (mQ.size() != 0 && inst_ready && !redirect_valid) void'(mQ.pop_front());
      if (rsp) begin
        if (redirect_valid || mDrop > 0) begin
          mDropped++;
          if (!redirect_valid) mDrop--;
        end else begin
          mQ.push_back('{mRspPc, imem_rsp_data});
          mRspPc += 4;
          mFetched++;
        end
      end
      if (hs) mFetchPc += 4;
      if (redirect_valid) begin
        mQ.delete();
        mFetchPc = redirect_pc;
        mRspPc   = redirect_pc;
        mDrop    = mOut - int'(rsp);
      end
      mOut = mOut + int'(hs) - int'(rsp);
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hsCount;
    bit found;
    logic [31:0] addrs[$];
`ifdef RV_FETCH_PERF_EN
    logic [31:0] perfBase;
`endif
    RST = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    // Reset release and streaming
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("rst_req_valid", imem_req_valid, 1'b0);
    checkOutput("rst_inst_valid", inst_valid, 1'b0);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("s1_first_req_valid", imem_req_valid, 1'b1);
    checkOutput("s1_addr0", imem_req_addr, 32'h0);
    checkOutput("s1_inst_valid_c0", inst_valid, 1'b0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("s1_addr1", imem_req_addr, 32'h4);
    checkOutput("s1_inst_valid_c1", inst_valid, 1'b0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("s1_addr2", imem_req_addr, 32'h8);
    checkOutput("s1_inst_valid_c2", inst_valid, 1'b1);
    checkOutput("s1_inst_pc_c2", inst_pc, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("s1_stream_valid", inst_valid, 1'b1);
      checkOutput("s1_stream_pc", inst_pc, 32'(4 * i));
    end

    // Decoder stalled: credit limits fetch to queue depth
    applyStimulus(0, 1, 32'h40, 1, 0);
    hsCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      if (imem_req_valid && imem_req_ready) hsCount++;
    end
    checkOutput("s2_req_count", hsCount, 4);
    checkOutput("s2_req_held_low", imem_req_valid, 1'b0);
    checkOutput("s2_head_pc", inst_pc, 32'h40);
    hsCount = 0;
    applyStimulus(0, 0, 0, 1, 1);
    if (imem_req_valid && imem_req_ready) hsCount++;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      if (imem_req_valid && imem_req_ready) hsCount++;
    end
    checkOutput("s2_req_after_pop", hsCount, 1);
    checkOutput("s2_head_after_pop", inst_pc, 32'h44);

    // Memory back-pressure holds the address
    applyStimulus(0, 1, 32'h0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("s3_req_valid0", imem_req_valid, 1'b1);
    checkOutput("s3_addr0", imem_req_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("s3_held_valid", imem_req_valid, 1'b1);
      checkOutput("s3_held_addr", imem_req_addr, 32'h4);
    end
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("s3_accept_addr", imem_req_addr, 32'h4);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("s3_next_addr", imem_req_addr, 32'h8);

    // Redirect with two outstanding requests
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1);
    memHold = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1);
    checkOutput("s4_credit_stall", imem_req_valid, 1'b0);
`ifdef RV_FETCH_PERF_EN
    perfBase = perf_dropped;
`endif
    applyStimulus(0, 1, 32'h100, 1, 1);
    memHold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 0, 0, 1, 1);
      if (inst_valid) begin
        found = 1'b1;
        checkOutput("s4_first_pc", inst_pc, 32'h100);
        checkOutput("s4_first_data", inst_data, instOf(32'h100));
`ifdef RV_FETCH_PERF_EN
        checkOutput("s4_perf_dropped", perf_dropped - perfBase, 32'd2);
`endif
      end
    end
    checkOutput("s4_delivery_wait", found, 1'b1);

    // Redirect with response and pop, then a second redirect while dropping
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0);
    memHold = 1'b1;
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    memHold = 1'b0;
    applyStimulus(0, 1, 32'h180, 1, 1);
    checkOutput("s5_rsp_in_redirect", imem_rsp_valid, 1'b1);
    checkOutput("s5_pop_in_redirect", inst_valid, 1'b1);
    memHold = 1'b1;
    applyStimulus(0, 1, 32'h200, 1, 1);
    memHold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 0, 0, 1, 1);
      if (inst_valid) begin
        found = 1'b1;
        checkOutput("s5_first_pc", inst_pc, 32'h200);
      end
    end
    checkOutput("s5_delivery_wait", found, 1'b1);

    // Fetch address wraps at 2^32
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 1, 32'hFFFF_FFF8, 1, 1);
    addrs.delete();
    for (int i = 0; i < 10 && addrs.size() < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 1);
      if (imem_req_valid && imem_req_ready) addrs.push_back(imem_req_addr);
    end
    checkOutput("s6_addr_count", addrs.size(), 3);
    if (addrs.size() == 3) begin
      checkOutput("s6_addr_a", addrs[0], 32'hFFFF_FFF8);
      checkOutput("s6_addr_b", addrs[1], 32'hFFFF_FFFC);
      checkOutput("s6_addr_wrap", addrs[2], 32'h0000_0000);
    end

    // Reset in mid-operation abandons in-flight work
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("s7_rst_req_valid", imem_req_valid, 1'b0);
    checkOutput("s7_rst_inst_valid", inst_valid, 1'b0);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("s7_first_req_valid", imem_req_valid, 1'b1);
    checkOutput("s7_first_addr", imem_req_addr, RESET_PC);
    checkOutput("s7_inst_valid", inst_valid, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 1);
    checkOutput("s7_stream_valid", inst_valid, 1'b1);

    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
